// File: rtl/memory_pkg.sv
// memory_pkg -- shared definitions for the memory responder and its requesters.
//   MEM_WIDTH_DEF  : default data word width in bits
//   MEM_ADDR_W_DEF : default address width (depth = 2**MEM_ADDR_W_DEF words)
//   state_e        : responder FSM encoding (ST_CLEAR sweeps the array, ST_IDLE serves requests)
package memory_pkg;

  localparam int MEM_WIDTH_DEF  = 8;
  localparam int MEM_ADDR_W_DEF = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_array.sv
// mem_array -- single-port synchronous RAM with a registered read port.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (read register only)
//   i_we   : write enable, writes i_din to i_addr on the rising edge
//   i_re   : read enable, loads o_dout from i_addr on the rising edge
//   i_addr : word address shared by read and write
//   i_din  : write data
//   o_dout : registered read data, holds until the next enabled read
module mem_array
  import memory_pkg::*;
#(
  parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [MEM_ADDR_W-1:0] i_addr,
  input  logic [MEM_WIDTH-1:0]  i_din,
  output logic [MEM_WIDTH-1:0]  o_dout
);

  localparam int DEPTH = 2 ** MEM_ADDR_W;

  logic [MEM_WIDTH-1:0] r_mem [DEPTH];
  logic [MEM_WIDTH-1:0] r_dout;

  // NOTE: the storage array has no reset term so it maps onto RAM macros;
  // clearing it is the job of the responder's sweep.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
  end

  // NOTE: sequential state is assigned with <= only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (i_re) begin
      r_dout <= r_mem[i_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/memory_responder.sv
// memory_responder -- request/response front end for a single-port RAM.
// After reset it optionally zeroes the whole array (one word per cycle),
// then accepts one read or write per cycle. Reads return data one cycle
// after acceptance with a one-cycle mem_valid pulse.
//   clk            : rising-edge clock
//   rst            : asynchronous active-low reset
//   mem_read       : read request strobe
//   mem_write      : write request strobe (wins over a simultaneous read)
//   mem_address    : word address of the request
//   mem_data_write : write data
//   mem_data_read  : registered read data, held between reads
//   mem_valid      : one-cycle pulse, mem_data_read is fresh
//   mem_ready      : requests are accepted while high
//   mem_error      : one-cycle pulse for a refused or dropped request
module memory_responder
  import memory_pkg::*;
#(
  parameter int MEM_WIDTH      = MEM_WIDTH_DEF,
  parameter int MEM_ADDR_W     = MEM_ADDR_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [MEM_WIDTH-1:0]  mem_data_write,
  output logic [MEM_WIDTH-1:0]  mem_data_read,
  output logic                  mem_valid,
  output logic                  mem_ready,
  output logic                  mem_error
);

  localparam int DEPTH = 2 ** MEM_ADDR_W;
  // One extra counter bit lets the sweep see DEPTH itself instead of wrapping to 0.
  localparam logic [MEM_ADDR_W:0] CNT_END   = (MEM_ADDR_W + 1)'(DEPTH);
  localparam logic [MEM_ADDR_W:0] CNT_ONE   = (MEM_ADDR_W + 1)'(1);
  localparam state_e              RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e                r_state;
  logic [MEM_ADDR_W:0]   r_clr_cnt;
  logic                  r_ready;
  logic                  r_valid;
  logic                  r_error;

  logic                  w_clearing;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_ram_we;
  logic [MEM_ADDR_W-1:0] w_ram_addr;
  logic [MEM_WIDTH-1:0]  w_ram_din;
  logic [MEM_ADDR_W:0]   w_cnt_nxt;

  assign w_clearing = (r_state == ST_CLEAR);
  // r_ready is only ever high in ST_IDLE, so no request can collide with the sweep.
  assign w_rd_acc   = r_ready & mem_read & ~mem_write;
  assign w_wr_acc   = r_ready & mem_write;
  assign w_cnt_nxt  = r_clr_cnt + CNT_ONE;

  assign w_ram_we   = w_clearing | w_wr_acc;
  assign w_ram_addr = w_clearing ? r_clr_cnt[MEM_ADDR_W-1:0] : mem_address;
  assign w_ram_din  = w_clearing ? '0 : mem_data_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RST_STATE;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      // Refused while busy, or the read half of a read+write collision.
      r_error <= (mem_read | mem_write) & (~r_ready | (mem_read & mem_write));
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == CNT_END) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= RST_STATE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .MEM_WIDTH  (MEM_WIDTH),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_mem_array (
    .clk    (clk),
    .rst_n  (rst),
    .i_we   (w_ram_we),
    .i_re   (w_rd_acc),
    .i_addr (w_ram_addr),
    .i_din  (w_ram_din),
    .o_dout (mem_data_read)
  );

  assign mem_valid = r_valid;
  assign mem_ready = r_ready;
  assign mem_error = r_error;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder -- randomized scoreboard bench for memory_responder.
// The driver applies one request per cycle on the falling edge and pushes
// the expected consequences (read data or error pulse, tagged with the edge
// number that produces them) into queues; the monitor pops them whenever
// the DUT raises mem_valid or mem_error.
module tb_memory_responder;
  import memory_pkg::*;

  localparam int W     = MEM_WIDTH_DEF;
  localparam int AW    = MEM_ADDR_W_DEF;
  localparam int DEPTH = 2 ** AW;
  localparam int SWEEP = DEPTH;  // clear sweep length in cycles

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mem_address = '0;
  logic [W-1:0]  mem_data_write = '0;
  logic [W-1:0]  mem_data_read;
  logic          mem_valid;
  logic          mem_ready;
  logic          mem_error;

  memory_responder dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_error      (mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           edge_n;
    logic [W-1:0] data;
  } rd_exp_t;

  rd_exp_t      rd_q[$];
  int           err_q[$];
  logic [W-1:0] model [DEPTH];
  logic [W-1:0] last_rd = '0;
  int           edge_cnt = 0;   // rising edges since the last reset release
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: consume expectations whenever the DUT signals an event.
  initial begin
    rd_exp_t e;
    int      ee;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (mem_valid) begin
          if (rd_q.size() == 0) begin
            check("unexpected_valid", 32'(mem_valid), 32'd0);
          end else begin
            e = rd_q.pop_front();
            check("valid_edge", edge_cnt, e.edge_n);
            check("read_data", 32'(mem_data_read), 32'(e.data));
          end
        end
        if (mem_error) begin
          if (err_q.size() == 0) begin
            check("unexpected_error", 32'(mem_error), 32'd0);
          end else begin
            ee = err_q.pop_front();
            check("error_edge", edge_cnt, ee);
          end
        end
      end
    end
  end

  // Called on a falling edge: apply one request, predict, advance one cycle.
  task automatic drive(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    bit rdy;
    rdy = (edge_cnt >= SWEEP);
    check("mem_ready", 32'(mem_ready), 32'(rdy));
    mem_read       = rd;
    mem_write      = wr;
    mem_address    = a;
    mem_data_write = d;
    if (rdy) begin
      if (wr) model[a] = d;
      if (rd && wr) begin
        err_q.push_back(edge_cnt + 1);
      end else if (rd) begin
        rd_q.push_back('{edge_cnt + 1, model[a]});
        last_rd = model[a];
      end
    end else if (rd || wr) begin
      err_q.push_back(edge_cnt + 1);
    end
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0);
  endtask

  // Called on a falling edge: assert reset, check outputs clear at once, release.
  task automatic do_reset();
    rst       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check("rst_data_read", 32'(mem_data_read), 32'd0);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_error", 32'(mem_error), 32'd0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    edge_cnt = 0;
    // Every accepted request comes after a completed sweep, so the model starts cleared.
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Sweep with mem_read held: refused every cycle, then accepted.
    repeat (SWEEP + 4) drive(1'b1, 1'b0, AW'($urandom), '0);
    idle(2);

    // Write then read-after-write, plus an untouched neighbour.
    drive(1'b0, 1'b1, 8'h10, 8'h5A);
    drive(1'b1, 1'b0, 8'h10, '0);
    drive(1'b1, 1'b0, 8'h11, '0);
    idle(1);

    // Back-to-back reads.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, AW'(i), W'(i + 1));
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, AW'(i), '0);
    idle(2);
    check("data_hold", 32'(mem_data_read), 32'(last_rd));

    // Read+write collision: write lands, read dropped with an error.
    drive(1'b1, 1'b1, 8'h20, 8'hC3);
    drive(1'b1, 1'b0, 8'h20, '0);
    idle(1);

    // Random traffic over a narrow window to force address reuse.
    repeat (400) begin
      logic [AW-1:0] a;
      a = ($urandom % 8 == 0) ? 8'hFF : AW'($urandom_range(0, 15));
      drive(1'($urandom), ($urandom % 3) == 0, a, W'($urandom));
    end
    idle(2);
    check("data_hold_rand", 32'(mem_data_read), 32'(last_rd));

    // Data at the top address, then a reset from the busy idle state.
    drive(1'b0, 1'b1, 8'hFF, 8'hAB);
    drive(1'b1, 1'b0, 8'hFF, '0);
    idle(1);
    do_reset();

    // Abort the sweep at address 100, then let the restarted sweep finish.
    repeat (100) drive(1'b1, 1'b0, AW'($urandom), '0);
    do_reset();
    repeat (SWEEP) drive(1'b1, 1'b0, AW'($urandom), '0);
    drive(1'b1, 1'b0, 8'hFF, '0);
    drive(1'b1, 1'b0, 8'h10, '0);
    idle(3);

    check("rd_q_drained", rd_q.size(), 32'd0);
    check("err_q_drained", err_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
